// File: rtl/ahb_csr_bridge_if.sv
// ahb_csr_bridge_if: AHB-Lite subordinate port plus CSR cpuif port.
// slave = bridge side, master = fabric + register block side.
interface ahb_csr_bridge_if #(
  parameter int AHB_DATA_WIDTH = 64,
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int CSR_DATA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12
);
  logic [AHB_ADDR_WIDTH-1:0]   haddr_i;
  logic [2:0]                  hsize_i;
  logic [1:0]                  htrans_i;
  logic                        hwrite_i;
  logic                        hsel_i;
  logic                        hready_i;
  logic [AHB_DATA_WIDTH-1:0]   hwdata_i;
  logic [AHB_DATA_WIDTH/8-1:0] hwstrb_i;
  logic [AHB_DATA_WIDTH-1:0]   hrdata_o;
  logic                        hreadyout_o;
  logic                        hresp_o;

  logic                        cpuif_req_o;
  logic                        cpuif_req_is_wr_o;
  logic [CSR_ADDR_WIDTH-1:0]   cpuif_addr_o;
  logic [CSR_DATA_WIDTH-1:0]   cpuif_wr_data_o;
  logic [CSR_DATA_WIDTH-1:0]   cpuif_wr_biten_o;
  logic                        cpuif_req_stall_wr_i;
  logic                        cpuif_req_stall_rd_i;
  logic                        cpuif_rd_ack_i;
  logic                        cpuif_rd_err_i;
  logic [CSR_DATA_WIDTH-1:0]   cpuif_rd_data_i;
  logic                        cpuif_wr_ack_i;
  logic                        cpuif_wr_err_i;

  modport slave (
    input  haddr_i, hsize_i, htrans_i, hwrite_i,
    input  hsel_i, hready_i, hwdata_i, hwstrb_i,
    output hrdata_o, hreadyout_o, hresp_o,
    output cpuif_req_o, cpuif_req_is_wr_o, cpuif_addr_o,
    output cpuif_wr_data_o, cpuif_wr_biten_o,
    input  cpuif_req_stall_wr_i, cpuif_req_stall_rd_i,
    input  cpuif_rd_ack_i, cpuif_rd_err_i, cpuif_rd_data_i,
    input  cpuif_wr_ack_i, cpuif_wr_err_i
  );

  modport master (
    output haddr_i, hsize_i, htrans_i, hwrite_i,
    output hsel_i, hready_i, hwdata_i, hwstrb_i,
    input  hrdata_o, hreadyout_o, hresp_o,
    input  cpuif_req_o, cpuif_req_is_wr_o, cpuif_addr_o,
    input  cpuif_wr_data_o, cpuif_wr_biten_o,
    output cpuif_req_stall_wr_i, cpuif_req_stall_rd_i,
    output cpuif_rd_ack_i, cpuif_rd_err_i, cpuif_rd_data_i,
    output cpuif_wr_ack_i, cpuif_wr_err_i
  );
endinterface

// File: rtl/ahb_csr_bridge.sv
// ahb_csr_bridge: AHB-Lite subordinate to CSR cpuif bridge.
// Ports: hclk_i, hreset_i (sync, active high), bus (AHB + cpuif).
module ahb_csr_bridge #(
  parameter int AHB_DATA_WIDTH = 64,
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int CSR_DATA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int ACK_TIMEOUT    = 255
) (
  input  logic hclk_i,
  input  logic hreset_i,
  ahb_csr_bridge_if.slave bus
);
  localparam int AB      = AHB_DATA_WIDTH / 8;
  localparam int CB      = CSR_DATA_WIDTH / 8;
  localparam int AHB_LSB = $clog2(AB);
  localparam int CSR_LSB = $clog2(CB);
  localparam int NLANE   = AHB_DATA_WIDTH / CSR_DATA_WIDTH;
  localparam int LW      = (NLANE > 1) ? $clog2(NLANE) : 1;
  localparam int CW      = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RESP = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]                r_state;
  logic [2:0]                w_next;
  logic [CSR_ADDR_WIDTH-1:0] r_addr;
  logic [CSR_LSB-1:0]        r_off;
  logic [2:0]                r_size;
  logic                      r_write;
  logic [LW-1:0]             r_lane;
  logic                      r_first;
  logic [CSR_DATA_WIDTH-1:0] r_wdata;
  logic [CB-1:0]             r_bmask;
  logic [CW-1:0]             r_cnt;
  logic [AHB_DATA_WIDTH-1:0] r_hrdata;

  logic                      w_accept;
  logic                      w_too_big;
  logic                      w_misal;
  logic                      w_bad;
  logic [AHB_ADDR_WIDTH-1:0] w_amask;
  logic [AHB_LSB-1:0]        w_boff;
  logic [LW-1:0]             w_lane;
  logic [CSR_ADDR_WIDTH-1:0] w_caddr;
  logic                      w_ack;
  logic                      w_err;
  logic                      w_tmo;
  logic                      w_req;
  logic                      w_wr_req;
  logic [CSR_DATA_WIDTH-1:0] w_wslice;
  logic [CB-1:0]             w_strb;
  logic [CB-1:0]             w_bmask;
  logic [CB-1:0]             w_bm_cur;
  logic [CSR_DATA_WIDTH-1:0] w_biten;
  logic                      w_unused;

  // cpuif outputs are frozen for all of REQ, so a stall needs no handling.
  assign w_unused = ^{bus.cpuif_req_stall_wr_i,
                      bus.cpuif_req_stall_rd_i,
                      bus.htrans_i[0]};

  assign w_accept = bus.hsel_i & bus.hready_i & bus.htrans_i[1]
                  & (r_state == S_IDLE | r_state == S_RESP);

  assign w_amask   = (AHB_ADDR_WIDTH'(1) << bus.hsize_i)
                   - AHB_ADDR_WIDTH'(1);
  assign w_too_big = (32'd8 << bus.hsize_i) > 32'(CSR_DATA_WIDTH);
  assign w_misal   = |(bus.haddr_i & w_amask);
  assign w_bad     = w_too_big | w_misal;

  assign w_boff  = bus.haddr_i[AHB_LSB-1:0];
  assign w_lane  = LW'(w_boff >> CSR_LSB);
  assign w_caddr = bus.haddr_i[CSR_ADDR_WIDTH-1:0]
                 & ~CSR_ADDR_WIDTH'(CB - 1);

  assign w_ack = r_write ? bus.cpuif_wr_ack_i : bus.cpuif_rd_ack_i;
  assign w_err = r_write ? bus.cpuif_wr_err_i : bus.cpuif_rd_err_i;
  assign w_tmo = (ACK_TIMEOUT != 0)
              && (32'(r_cnt) + 32'd1 >= 32'(ACK_TIMEOUT));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) w_next = w_bad ? S_ERR1 : S_REQ;
        else          w_next = S_IDLE;
      end
      S_REQ: begin
        if (w_ack)      w_next = w_err ? S_ERR1 : S_RESP;
        else if (w_tmo) w_next = S_ERR1;
      end
      S_ERR1:  w_next = S_ERR2;
      S_ERR2:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_wslice = '0;
    w_strb   = '0;
    for (int l = 0; l < NLANE; l++) begin
      if (r_lane == LW'(l)) begin
        w_wslice = bus.hwdata_i[l*CSR_DATA_WIDTH +: CSR_DATA_WIDTH];
        w_strb   = bus.hwstrb_i[l*CB +: CB];
      end
    end
  end

  // Byte enabled when inside [offset, offset+size) and strobed.
  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < CB; b++) begin
      w_bmask[b] = w_strb[b]
                && (b >= int'(r_off))
                && (b < int'(r_off) + (1 << r_size));
    end
  end

  assign w_req    = (r_state == S_REQ);
  assign w_wr_req = w_req & r_write;
  // First REQ cycle uses the live data phase; later cycles the copy.
  assign w_bm_cur = r_first ? w_bmask : r_bmask;

  always_comb begin
    w_biten = '0;
    for (int b = 0; b < CB; b++) begin
      w_biten[b*8 +: 8] = {8{w_wr_req & w_bm_cur[b]}};
    end
  end

  assign bus.cpuif_req_o       = w_req;
  assign bus.cpuif_req_is_wr_o = w_wr_req;
  assign bus.cpuif_addr_o      = w_req ? r_addr : '0;
  assign bus.cpuif_wr_data_o   = w_wr_req
                               ? (r_first ? w_wslice : r_wdata) : '0;
  assign bus.cpuif_wr_biten_o  = w_biten;

  assign bus.hreadyout_o = ~(r_state == S_REQ | r_state == S_ERR1);
  assign bus.hresp_o     = (r_state == S_ERR1) | (r_state == S_ERR2);
  assign bus.hrdata_o    = r_hrdata;

  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_off    <= '0;
      r_size   <= '0;
      r_write  <= 1'b0;
      r_lane   <= '0;
      r_first  <= 1'b0;
      r_wdata  <= '0;
      r_bmask  <= '0;
      r_cnt    <= '0;
      r_hrdata <= '0;
    end else begin
      r_state <= w_next;
      r_first <= w_accept & ~w_bad;
      if (w_accept) begin
        r_addr  <= w_caddr;
        r_off   <= bus.haddr_i[CSR_LSB-1:0];
        r_size  <= bus.hsize_i;
        r_write <= bus.hwrite_i;
        r_lane  <= w_lane;
        r_cnt   <= '0;
      end
      if (w_req) begin
        if (r_first) begin
          r_wdata <= w_wslice;
          r_bmask <= w_bmask;
        end
        if (!w_ack) r_cnt <= r_cnt + CW'(1);
        if (w_ack && !w_err && !r_write) begin
          r_hrdata <= {NLANE{bus.cpuif_rd_data_i}};
        end
      end
    end
  end
endmodule

// File: tb/tb_ahb_csr_bridge.sv
// tb_ahb_csr_bridge: vector table + scoreboard bench for ahb_csr_bridge.
// The bench plays both the AHB master and the CSR responder.
module tb_ahb_csr_bridge;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [7:0]  strb;
    int          stall;
    logic        err;
    logic        noack;
    logic [31:0] rdata;
    int          e_req;
    int          e_waits;
    logic        e_resp;
    logic [11:0] e_addr;
    logic [31:0] e_biten;
    logic [31:0] e_wdata;
    logic [63:0] e_hrdata;
  } vec_t;

  vec_t tbl[12];
  vec_t sb[$];
  vec_t rv;

  ahb_csr_bridge_if #(
    .AHB_DATA_WIDTH(64), .AHB_ADDR_WIDTH(32),
    .CSR_DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)
  ) bus ();

  ahb_csr_bridge #(
    .AHB_DATA_WIDTH(64), .AHB_ADDR_WIDTH(32),
    .CSR_DATA_WIDTH(32), .CSR_ADDR_WIDTH(12),
    .ACK_TIMEOUT(4)
  ) dut (
    .hclk_i(clk),
    .hreset_i(rst),
    .bus(bus)
  );

  assign bus.hready_i = bus.hreadyout_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h required %h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a,
                            input logic [2:0] sz);
    bus.hsel_i   = 1'b1;
    bus.htrans_i = 2'b10;
    bus.haddr_i  = a;
    bus.hsize_i  = sz;
    bus.hwrite_i = wr;
  endtask

  task automatic bus_idle();
    bus.hsel_i   = 1'b0;
    bus.htrans_i = 2'b00;
    bus.haddr_i  = '0;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t        e;
    int          waits, nreq, n;
    logic        done, stable, err1;
    logic [11:0] a0;
    logic [31:0] b0, d0;
    logic        w0;
    addr_phase(v.wr, v.addr, v.size);
    sb.push_back(v);
    cyc();
    bus_idle();
    bus.hwdata_i = v.wdata;
    bus.hwstrb_i = v.strb;
    #1;
    waits = 0; nreq = 0; n = 0;
    done = 1'b0; stable = 1'b1; err1 = 1'b0;
    a0 = '0; b0 = '0; d0 = '0; w0 = 1'b0;
    while (!done && n < 20) begin
      n++;
      if (bus.hreadyout_o) begin
        done = 1'b1;
      end else begin
        waits++;
        if (bus.hresp_o) err1 = 1'b1;
        if (bus.cpuif_req_o) begin
          nreq++;
          if (nreq == 1) begin
            a0 = bus.cpuif_addr_o;
            b0 = bus.cpuif_wr_biten_o;
            d0 = bus.cpuif_wr_data_o;
            w0 = bus.cpuif_req_is_wr_o;
          end else if ({bus.cpuif_addr_o, bus.cpuif_wr_biten_o,
                        bus.cpuif_wr_data_o, bus.cpuif_req_is_wr_o}
                       !== {a0, b0, d0, w0}) begin
            stable = 1'b0;
          end
          if (nreq <= v.stall) begin
            bus.cpuif_req_stall_wr_i = v.wr;
            bus.cpuif_req_stall_rd_i = ~v.wr;
          end else if (!v.noack) begin
            bus.cpuif_wr_ack_i  = v.wr;
            bus.cpuif_wr_err_i  = v.wr & v.err;
            bus.cpuif_rd_ack_i  = ~v.wr;
            bus.cpuif_rd_err_i  = ~v.wr & v.err;
            bus.cpuif_rd_data_i = v.rdata;
          end
        end
        cyc();
        bus.cpuif_req_stall_wr_i = 1'b0;
        bus.cpuif_req_stall_rd_i = 1'b0;
        bus.cpuif_wr_ack_i = 1'b0;
        bus.cpuif_wr_err_i = 1'b0;
        bus.cpuif_rd_ack_i = 1'b0;
        bus.cpuif_rd_err_i = 1'b0;
        bus.cpuif_rd_data_i = '0;
        // The bridge must work from its own copy after the first cycle.
        if (nreq == 1) begin
          bus.hwdata_i = ~v.wdata;
          bus.hwstrb_i = ~v.strb;
        end
        #1;
      end
    end
    e = sb.pop_front();
    chk("resp_done", done, 1'b1);
    chk("waits", waits, e.e_waits);
    chk("req_cycles", nreq, e.e_req);
    chk("hresp", bus.hresp_o, e.e_resp);
    chk("err_first", err1, e.e_resp);
    chk("hrdata", bus.hrdata_o, e.e_hrdata);
    if (e.e_req > 0) begin
      chk("cpu_addr", a0, e.e_addr);
      chk("cpu_is_wr", w0, e.wr);
      chk("cpu_biten", b0, e.e_biten);
      chk("stable", stable, 1'b1);
      if (e.wr) chk("cpu_wdata", d0, e.e_wdata);
    end
    bus.hwdata_i = '0;
    bus.hwstrb_i = '0;
    cyc();
  endtask

  task automatic chk_reset_vals();
    chk("rst_hreadyout", bus.hreadyout_o, 1'b1);
    chk("rst_hresp", bus.hresp_o, 1'b0);
    chk("rst_hrdata", bus.hrdata_o, 64'h0);
    chk("rst_req", bus.cpuif_req_o, 1'b0);
    chk("rst_is_wr", bus.cpuif_req_is_wr_o, 1'b0);
    chk("rst_addr", bus.cpuif_addr_o, 12'h0);
    chk("rst_wdata", bus.cpuif_wr_data_o, 32'h0);
    chk("rst_biten", bus.cpuif_wr_biten_o, 32'h0);
  endtask

  localparam logic [63:0] HR0 = 64'hDEADBEEF_DEADBEEF;

  initial begin
    n_pass = 0;
    n_total = 0;
    // wr addr sz wdata strb stall err noack rdata
    // e_req e_waits e_resp e_addr e_biten e_wdata e_hrdata
    tbl[0]  = '{1'b0, 32'h104, 3'd0 + 3'd2, 64'h0, 8'h00, 0, 1'b0, 1'b0,
                32'hDEADBEEF, 1, 1, 1'b0, 12'h104, 32'h0, 32'h0, HR0};
    tbl[1]  = '{1'b1, 32'h006, 3'd0, 64'h55A57788_11223344, 8'hFF, 0,
                1'b0, 1'b0, 32'h0, 1, 1, 1'b0, 12'h004, 32'h00FF0000,
                32'h55A57788, HR0};
    tbl[2]  = '{1'b1, 32'h00C, 3'd1, 64'hCAFEBABE_0BADF00D, 8'h10, 3,
                1'b0, 1'b0, 32'h0, 4, 4, 1'b0, 12'h00C, 32'h000000FF,
                32'hCAFEBABE, HR0};
    tbl[3]  = '{1'b1, 32'h010, 3'd2, 64'h01234567_89ABCDEF, 8'hFF, 0,
                1'b0, 1'b0, 32'h0, 1, 1, 1'b0, 12'h010, 32'hFFFFFFFF,
                32'h89ABCDEF, HR0};
    tbl[4]  = '{1'b0, 32'h100, 3'd3, 64'h0, 8'h00, 0, 1'b0, 1'b0,
                32'h0, 0, 1, 1'b1, 12'h0, 32'h0, 32'h0, HR0};
    tbl[5]  = '{1'b0, 32'h102, 3'd2, 64'h0, 8'h00, 0, 1'b0, 1'b0,
                32'h0, 0, 1, 1'b1, 12'h0, 32'h0, 32'h0, HR0};
    tbl[6]  = '{1'b1, 32'h003, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0,
                1'b0, 1'b0, 32'h0, 0, 1, 1'b1, 12'h0, 32'h0, 32'h0, HR0};
    tbl[7]  = '{1'b0, 32'h020, 3'd2, 64'h0, 8'h00, 0, 1'b1, 1'b0,
                32'h12345678, 1, 2, 1'b1, 12'h020, 32'h0, 32'h0, HR0};
    tbl[8]  = '{1'b0, 32'h030, 3'd2, 64'h0, 8'h00, 0, 1'b0, 1'b1,
                32'h0, 4, 5, 1'b1, 12'h030, 32'h0, 32'h0, HR0};
    tbl[9]  = '{1'b1, 32'h7FE, 3'd1, 64'hA1B2C3D4_00000000, 8'hFF, 0,
                1'b1, 1'b0, 32'h0, 1, 2, 1'b1, 12'h7FC, 32'hFFFF0000,
                32'hA1B2C3D4, HR0};
    tbl[10] = '{1'b0, 32'h0001_21FC, 3'd2, 64'h0, 8'h00, 0, 1'b0, 1'b0,
                32'h13579BDF, 1, 1, 1'b0, 12'h1FC, 32'h0, 32'h0,
                64'h13579BDF_13579BDF};
    tbl[11] = '{1'b0, 32'h005, 3'd0, 64'h0, 8'h00, 0, 1'b0, 1'b0,
                32'h0000AB00, 1, 1, 1'b0, 12'h004, 32'h0, 32'h0,
                64'h0000AB00_0000AB00};

    rst = 1'b1;
    bus_idle();
    bus.hsize_i = '0;
    bus.hwrite_i = 1'b0;
    bus.hwdata_i = '0;
    bus.hwstrb_i = '0;
    bus.cpuif_req_stall_wr_i = 1'b0;
    bus.cpuif_req_stall_rd_i = 1'b0;
    bus.cpuif_rd_ack_i = 1'b0;
    bus.cpuif_rd_err_i = 1'b0;
    bus.cpuif_rd_data_i = '0;
    bus.cpuif_wr_ack_i = 1'b0;
    bus.cpuif_wr_err_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;
    cyc();

    // BUSY selected and NONSEQ unselected: no CSR access, no wait.
    addr_phase(1'b0, 32'h100, 3'd2);
    bus.htrans_i = 2'b01;
    cyc();
    chk("busy_req", bus.cpuif_req_o, 1'b0);
    chk("busy_ready", bus.hreadyout_o, 1'b1);
    addr_phase(1'b0, 32'h100, 3'd2);
    bus.hsel_i = 1'b0;
    cyc();
    chk("unsel_req", bus.cpuif_req_o, 1'b0);
    chk("unsel_ready", bus.hreadyout_o, 1'b1);
    bus_idle();
    cyc();

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Back-to-back reads, second accepted during the first RESP.
    addr_phase(1'b0, 32'h200, 3'd2);
    cyc();
    chk("b2b_req_a", bus.cpuif_req_o, 1'b1);
    chk("b2b_addr_a", bus.cpuif_addr_o, 12'h200);
    addr_phase(1'b0, 32'h208, 3'd2);
    bus.cpuif_rd_ack_i = 1'b1;
    bus.cpuif_rd_data_i = 32'hA0A0A0A0;
    cyc();
    bus.cpuif_rd_ack_i = 1'b0;
    bus.cpuif_rd_data_i = '0;
    chk("b2b_resp_a", {bus.hreadyout_o, bus.hresp_o}, 2'b10);
    chk("b2b_data_a", bus.hrdata_o, 64'hA0A0A0A0_A0A0A0A0);
    cyc();
    bus_idle();
    chk("b2b_req_b", bus.cpuif_req_o, 1'b1);
    chk("b2b_addr_b", bus.cpuif_addr_o, 12'h208);
    chk("b2b_wait_b", bus.hreadyout_o, 1'b0);
    bus.cpuif_rd_ack_i = 1'b1;
    bus.cpuif_rd_data_i = 32'h0B0B0B0B;
    cyc();
    bus.cpuif_rd_ack_i = 1'b0;
    bus.cpuif_rd_data_i = '0;
    chk("b2b_resp_b", {bus.hreadyout_o, bus.hresp_o}, 2'b10);
    chk("b2b_data_b", bus.hrdata_o, 64'h0B0B0B0B_0B0B0B0B);
    cyc();
    chk("b2b_idle", bus.cpuif_req_o, 1'b0);

    // Reset in the middle of REQ, then a clean transfer.
    addr_phase(1'b0, 32'h040, 3'd2);
    cyc();
    bus_idle();
    chk("mid_req", bus.cpuif_req_o, 1'b1);
    rst = 1'b1;
    cyc();
    chk_reset_vals();
    rst = 1'b0;
    cyc();
    rv = '{1'b0, 32'h044, 3'd2, 64'h0, 8'h00, 0, 1'b0, 1'b0,
           32'h55AA55AA, 1, 1, 1'b0, 12'h044, 32'h0, 32'h0,
           64'h55AA55AA_55AA55AA};
    run_vec(rv);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
